// File: rtl/scl180_sparecell_monitor_if.sv
// Wishbone slave bundle for the spare-cell monitor; signal names follow the
// management-area port names so the wrapper wiring stays one-to-one.
interface scl180_sparecell_monitor_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [3:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/scl180_sparecell_monitor.sv
// Spare-cell tie-low monitor: synchronises up to 32 LO pins, debounces highs into
// sticky FAULT bits and a saturating event COUNT. IRQ output under SPARECELL_MON_IRQ_EN.
module scl180_sparecell_monitor #(
    parameter int unsigned NUM_CELLS = 16,
    parameter int unsigned DEBOUNCE  = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [NUM_CELLS-1:0]  sc_lo,
    scl180_sparecell_monitor_if.slave wbs
`ifdef SPARECELL_MON_IRQ_EN
    ,
    output logic                  irq_o
`endif
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned DATA_W  = 32;

    logic [NUM_CELLS-1:0] sync1_q, sync1_d;
    logic [NUM_CELLS-1:0] sync2_q, sync2_d;
    logic [CNT_W-1:0]     cnt_q [NUM_CELLS];
    logic [CNT_W-1:0]     cnt_d [NUM_CELLS];
    logic [NUM_CELLS-1:0] fault_q, fault_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 en_q, en_d;
    logic                 irq_en_q, irq_en_d;
    logic                 irq_q, irq_d;
    logic                 ack_q, ack_d;
    logic [DATA_W-1:0]    dat_q, dat_d;

    logic                 req;
    logic                 wr;
    logic [1:0]           reg_sel;
    logic [NUM_CELLS-1:0] set_vec;
    logic [NUM_CELLS-1:0] w1c;
    logic                 rise;
    logic [DATA_W-1:0]    rdata;
    logic                 unused_bits;

    assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i};

    always_comb begin
        sync1_d  = sc_lo;
        sync2_d  = sync1_q;
        fault_d  = fault_q;
        count_d  = count_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        set_vec  = '0;
        w1c      = '0;
        rdata    = '0;

        req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
        wr      = req & wbs.wbs_we_i;
        reg_sel = wbs.wbs_adr_i[3:2];

        // Debounce: counters only run while enabled, any low sample restarts them.
        for (int i = 0; i < int'(NUM_CELLS); i++) begin
            if (!en_q || !sync2_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_W'(DEBOUNCE)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            set_vec[i] = (cnt_d[i] == CNT_W'(DEBOUNCE));
        end

        if (wr && reg_sel == 2'd0) begin
            w1c = wbs.wbs_dat_i[NUM_CELLS-1:0];
        end
        // A set in the same cycle as a clear wins.
        fault_d = (fault_q & ~w1c) | set_vec;
        rise    = |(fault_d & ~fault_q);

        if (wr && reg_sel == 2'd2) begin
            count_d = rise ? COUNT_W'(1) : '0;
        end else if (rise && count_q != {COUNT_W{1'b1}}) begin
            count_d = count_q + COUNT_W'(1);
        end

        if (wr && reg_sel == 2'd3) begin
            en_d = wbs.wbs_dat_i[0];
`ifdef SPARECELL_MON_IRQ_EN
            irq_en_d = wbs.wbs_dat_i[1];
`endif
        end

        unique case (reg_sel)
            2'd0:    rdata = DATA_W'(fault_q);
            2'd1:    rdata = DATA_W'(sync2_q);
            2'd2:    rdata = DATA_W'(count_q);
            default: rdata = DATA_W'({irq_en_q, en_q});
        endcase

        ack_d = req;
        dat_d = (req && !wbs.wbs_we_i) ? rdata : '0;
        irq_d = irq_en_q & (|fault_q);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            for (int i = 0; i < int'(NUM_CELLS); i++) cnt_q[i] <= '0;
            fault_q  <= '0;
            count_q  <= '0;
            en_q     <= 1'b1;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            for (int i = 0; i < int'(NUM_CELLS); i++) cnt_q[i] <= cnt_d[i];
            fault_q  <= fault_d;
            count_q  <= count_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

`ifdef SPARECELL_MON_IRQ_EN
    assign irq_o = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_scl180_sparecell_monitor.sv
// Bench for scl180_sparecell_monitor: windowed-history register model checked every
// cycle, plus directed register reads against hand-computed values.
module tb_scl180_sparecell_monitor;

    localparam int NC = 16;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] sc_lo = '0;
    logic          chk_en = 1'b0;
    int            n_chk = 0;
    int            n_pass = 0;

    scl180_sparecell_monitor_if wb ();
`ifdef SPARECELL_MON_IRQ_EN
    logic irq_o;
`endif

    scl180_sparecell_monitor #(.NUM_CELLS(NC), .DEBOUNCE(DB)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .sc_lo    (sc_lo),
        .wbs      (wb.slave)
`ifdef SPARECELL_MON_IRQ_EN
        ,
        .irq_o    (irq_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: FAULT[i] sets when the last DB enabled edges all saw a high sample
    // taken two edges earlier; everything else follows the register rules.
    logic [NC-1:0] h [0:DB];
    logic          enh [0:DB-1];
    logic [NC-1:0] m_fault = '0;
    logic [7:0]    m_count = '0;
    logic          m_en = 1'b1, m_irq_en = 1'b0, m_ack = 1'b0, m_irq = 1'b0;
    logic [31:0]   m_dat = '0;
    logic [NC-1:0] setv, w1c, nf;
    logic          req, wr, rose;
    logic [1:0]    ra;
    logic [31:0]   rd;

    always @(posedge clk) begin
        if (rst) begin
            m_fault = '0; m_count = '0; m_en = 1'b1; m_irq_en = 1'b0;
            m_ack = 1'b0; m_dat = '0; m_irq = 1'b0;
            for (int j = 0; j <= DB; j++) h[j] = '0;
            for (int j = 0; j < DB; j++) enh[j] = 1'b0;
            enh[0] = 1'b1;
        end else begin
            setv = '1;
            for (int j = 0; j < DB; j++) setv &= enh[j] ? h[j+1] : '0;
            req = wb.wbs_cyc_i && wb.wbs_stb_i && !m_ack;
            wr  = req && wb.wbs_we_i;
            ra  = wb.wbs_adr_i[3:2];
            case (ra)
                2'd0:    rd = 32'(m_fault);
                2'd1:    rd = 32'(h[1]);
                2'd2:    rd = 32'(m_count);
                default: rd = {30'd0, m_irq_en, m_en};
            endcase
            w1c  = (wr && ra == 2'd0) ? wb.wbs_dat_i[NC-1:0] : '0;
            nf   = (m_fault & ~w1c) | setv;
            rose = (nf & ~m_fault) != '0;
            if (wr && ra == 2'd2) m_count = rose ? 8'd1 : 8'd0;
            else if (rose && m_count < 8'd255) m_count = m_count + 8'd1;
            m_irq = m_irq_en && (m_fault != '0);
            if (wr && ra == 2'd3) begin
                m_en = wb.wbs_dat_i[0];
`ifdef SPARECELL_MON_IRQ_EN
                m_irq_en = wb.wbs_dat_i[1];
`endif
            end
            m_fault = nf;
            m_dat   = (req && !wb.wbs_we_i) ? rd : 32'd0;
            m_ack   = req;
            for (int j = DB; j > 0; j--) h[j] = h[j-1];
            h[0] = sc_lo;
            for (int j = DB - 1; j > 0; j--) enh[j] = enh[j-1];
            enh[0] = m_en;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack_cycle", 32'(wb.wbs_ack_o), 32'(m_ack));
            check("dat_cycle", wb.wbs_dat_o, m_dat);
`ifdef SPARECELL_MON_IRQ_EN
            check("irq_cycle", 32'(irq_o), 32'(m_irq));
`endif
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic we, input logic [3:0] a, input logic [31:0] d,
                             output logic [31:0] rdat);
        bit got = 1'b0;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = a;    wb.wbs_dat_i = d;
        rdat = '0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk); #1;
            if (wb.wbs_ack_o) begin got = 1'b1; rdat = wb.wbs_dat_o; end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(1'b1, a, d, dummy);
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_access(1'b0, a, 32'd0, v);
        check(name, v, exp);
    endtask

    initial begin
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;

        // T1 reset
        @(posedge clk); chk_en = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        check("t1_ack", 32'(wb.wbs_ack_o), 32'd0);
        read_check("t1_fault", 4'h0, 32'h0);
        read_check("t1_live",  4'h4, 32'h0);
        read_check("t1_count", 4'h8, 32'h0);
        read_check("t1_ctrl",  4'hC, 32'h1);

        // T2 debounce
        sc_lo = 16'h0020; wait_cycles(3); sc_lo = '0;
        wait_cycles(10);
        read_check("t2_short_pulse", 4'h0, 32'h0);
        sc_lo = 16'h0020; wait_cycles(5);
        read_check("t2_before_set", 4'h0, 32'h0);
        read_check("t2_fault",      4'h0, 32'h20);
        read_check("t2_count",      4'h8, 32'h1);

        // T3 simultaneous rise, then saturation
        sc_lo = 16'h0029; wait_cycles(8);
        read_check("t3_fault", 4'h0, 32'h29);
        read_check("t3_count", 4'h8, 32'h2);
        for (int k = 0; k < 300; k++) begin
            sc_lo = '0; wait_cycles(3);
            wb_write(4'h0, 32'hFFFF);
            sc_lo = 16'h0001; wait_cycles(7);
        end
        read_check("t3_count_sat", 4'h8, 32'hFF);

        // T4 set beats clear; count clear beats increment
        sc_lo = 16'h0021; wait_cycles(8);
        wb_write(4'h0, 32'h21);
        read_check("t4_fault_held", 4'h0, 32'h21);
        read_check("t4_count_held", 4'h8, 32'hFF);
        sc_lo = 16'h00A1; wait_cycles(5);
        wb_write(4'h8, 32'h0);
        read_check("t4_count_clr_inc", 4'h8, 32'h1);
        read_check("t4_fault", 4'h0, 32'hA1);

        // T5 disable
        sc_lo = '0; wait_cycles(4);
        wb_write(4'hC, 32'h0);
        wb_write(4'h0, 32'hFFFF);
        sc_lo = 16'hFFFF; wait_cycles(20);
        read_check("t5_fault_off", 4'h0, 32'h0);
        read_check("t5_live",      4'h4, 32'hFFFF);
        read_check("t5_ctrl",      4'hC, 32'h0);
        wb_write(4'hC, 32'h1);
        wait_cycles(6);
        read_check("t5_fault_on", 4'h0, 32'hFFFF);
        read_check("t5_count",    4'h8, 32'h2);

        // T6 interrupt
        sc_lo = '0; wait_cycles(4);
        wb_write(4'h0, 32'hFFFF);
        wb_write(4'hC, 32'h3);
`ifdef SPARECELL_MON_IRQ_EN
        read_check("t6_ctrl", 4'hC, 32'h3);
        sc_lo = 16'h0004; wait_cycles(8);
        check("t6_irq_set", 32'(irq_o), 32'd1);
        sc_lo = '0; wait_cycles(4);
        wb_write(4'h0, 32'h4);
        check("t6_irq_ack_cycle", 32'(irq_o), 32'd1);
        wait_cycles(1);
        check("t6_irq_clear", 32'(irq_o), 32'd0);
        wb_write(4'hC, 32'h1);
`else
        read_check("t6_ctrl_noirq", 4'hC, 32'h1);
`endif

        // Reset in the middle of a write
        wait_cycles(2);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
        wb.wbs_adr_i = 4'hC; wb.wbs_dat_i = 32'h0;
        rst = 1'b1;
        wait_cycles(1);
        check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        rst = 1'b0;
        read_check("rst_ctrl",  4'hC, 32'h1);
        read_check("rst_count", 4'h8, 32'h0);
        read_check("rst_fault", 4'h0, 32'h0);

        wait_cycles(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
